// File: rtl/clk_div_ctrl_if.sv
// Divisor-change bus between two requesting clients, the reconfiguration controller and the divider.
// master = client/config side, slave = controller side.
interface clk_div_ctrl_if #(
  parameter int DW = 16
);
  logic          req0;
  logic [DW-1:0] div0;
  logic          ack0;
  logic          req1;
  logic [DW-1:0] div1;
  logic          ack1;
  logic          err;
  logic [DW-1:0] divisor;
  logic          div_rst_n;
  logic          busy;

  modport master (
    output req0, div0, req1, div1,
    input  ack0, ack1, err, divisor, div_rst_n, busy
  );

  modport slave (
    input  req0, div0, req1, div1,
    output ack0, ack1, err, divisor, div_rst_n, busy
  );
endinterface

// File: rtl/clk_div_ctrl.sv
// Arbitrates divisor-change requests from two clients and applies the winner at a divider period
// boundary, pulsing the divider reset so clkout restarts without runt or stretched pulses.
module clk_div_ctrl #(
  parameter int          DW         = 16,
  parameter int unsigned RESET_DIV  = 5,
  parameter int unsigned MIN_DIV    = 1,
  parameter int          RST_CYCLES = 2
) (
  input  logic           i_clkin,
  input  logic           i_reset,
  clk_div_ctrl_if.slave  bus
);

  localparam int            RW          = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam logic [DW-1:0] L_RESET_DIV = DW'(RESET_DIV);
  localparam logic [DW-1:0] L_MIN_DIV   = DW'(MIN_DIV);
  localparam logic [RW-1:0] L_RCNT_INIT = RW'(RST_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHECK,
    S_WAIT,
    S_APPLY,
    S_RELEASE
  } state_t;

  state_t        r_state;
  logic [DW-1:0] r_divisor;
  logic [DW-1:0] r_pend;
  logic [DW-1:0] r_pcnt;
  logic [RW-1:0] r_rcnt;
  logic          r_div_rst_n;
  logic          r_gnt;
  logic          r_rr;
  logic          r_ack0;
  logic          r_ack1;
  logic          r_err;
  logic          r_busy;

  logic          w_boundary;
  logic          w_any_req;
  logic          w_pick1;

  assign w_boundary = (r_pcnt == r_divisor);
  assign w_any_req  = bus.req0 | bus.req1;
  // Client 1 wins when it is alone, or when both ask and the rr pointer favours it.
  assign w_pick1    = bus.req1 & (~bus.req0 | r_rr);

  // Phase of the attached divider: restarts from 0 whenever its reset is released.
  always_ff @(posedge i_clkin or negedge i_reset) begin
    if (!i_reset) begin
      r_pcnt <= '0;
    end else if (!r_div_rst_n || w_boundary) begin
      r_pcnt <= '0;
    end else begin
      r_pcnt <= r_pcnt + 1'b1;
    end
  end

  always_ff @(posedge i_clkin or negedge i_reset) begin
    if (!i_reset) begin
      r_state     <= S_IDLE;
      r_divisor   <= L_RESET_DIV;
      r_pend      <= '0;
      r_rcnt      <= '0;
      r_div_rst_n <= 1'b0;
      r_gnt       <= 1'b0;
      r_rr        <= 1'b0;
      r_ack0      <= 1'b0;
      r_ack1      <= 1'b0;
      r_err       <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_ack0 <= 1'b0;
      r_ack1 <= 1'b0;
      r_err  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_div_rst_n <= 1'b1;
          if (w_any_req) begin
            r_gnt   <= w_pick1;
            r_pend  <= w_pick1 ? bus.div1 : bus.div0;
            if (bus.req0 && bus.req1) begin
              r_rr <= ~w_pick1;
            end
            r_state <= S_CHECK;
            r_busy  <= 1'b1;
          end
        end
        S_CHECK: begin
          if (r_pend < L_MIN_DIV) begin
            r_ack0  <= ~r_gnt;
            r_ack1  <= r_gnt;
            r_err   <= 1'b1;
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end else if (r_pend == r_divisor) begin
            r_ack0  <= ~r_gnt;
            r_ack1  <= r_gnt;
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end else begin
            r_state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (w_boundary) begin
            r_divisor   <= r_pend;
            r_div_rst_n <= 1'b0;
            r_rcnt      <= L_RCNT_INIT;
            r_state     <= S_APPLY;
          end
        end
        S_APPLY: begin
          // Releasing on the exit edge keeps the divider reset low for exactly RST_CYCLES cycles.
          if (r_rcnt == '0) begin
            r_div_rst_n <= 1'b1;
            r_state     <= S_RELEASE;
          end else begin
            r_rcnt <= r_rcnt - 1'b1;
          end
        end
        S_RELEASE: begin
          r_div_rst_n <= 1'b1;
          r_ack0      <= ~r_gnt;
          r_ack1      <= r_gnt;
          r_state     <= S_IDLE;
          r_busy      <= 1'b0;
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.ack0      = r_ack0;
  assign bus.ack1      = r_ack1;
  assign bus.err       = r_err;
  assign bus.divisor   = r_divisor;
  assign bus.div_rst_n = r_div_rst_n;
  assign bus.busy      = r_busy;

endmodule

// File: tb/tb_clk_div_ctrl.sv
// Bench for clk_div_ctrl: directed steps plus randomized rounds checked against a transaction-level
// model of the divider phase, the round-robin pointer and the change timing.
module tb_clk_div_ctrl;
  localparam int DW   = 16;
  localparam int RST  = 2;
  localparam int MINV = 1;
  localparam int RDIV = 5;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  clk_div_ctrl_if #(.DW(DW)) bus ();

  clk_div_ctrl #(
    .DW(DW), .RESET_DIV(RDIV), .MIN_DIV(MINV), .RST_CYCLES(RST)
  ) dut (
    .i_clkin(clk),
    .i_reset(rst_n),
    .bus(bus)
  );

  longint cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;

  // Model: current divisor, edge at which the divider last left reset, arbitration preference.
  int     m_div;
  longint m_rise;
  bit     m_rr;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Divider phase just before edge k is (k - m_rise - 1) mod (m_div + 1); a change lands on the
  // first edge from s+2 whose phase equals m_div.
  function automatic void predict(input longint s, input int v, output longint ack,
                                  output longint kb, output int nd, output bit e, output int lows);
    kb = -1; lows = 0; e = 1'b0; nd = m_div;
    if (v < MINV) begin
      ack = s + 1;
      e   = 1'b1;
    end else if (v == m_div) begin
      ack = s + 1;
    end else begin
      longint k;
      k = s + 2;
      while (!(k > m_rise && ((k - m_rise - 1) % (m_div + 1)) == m_div)) k++;
      kb   = k;
      ack  = k + RST + 1;
      nd   = v;
      lows = RST;
    end
  endfunction

  task automatic round(input bit u0, input bit u1, input int v0, input int v1);
    longint s, nxt;
    longint a[2], kb[2], got_ack[2];
    int     nd[2], lw[2], got_div[2], ack_cnt[2], order[2];
    bit     er[2], got_err[2];
    int     n, c, exp_lows, lows_seen, prev_div, stray_err;
    longint exp_chg[$], got_chg[$];
    bit     done;
    s = cyc + 1;
    if (u0 && u1) begin
      order[0] = int'(m_rr); order[1] = int'(!m_rr); n = 2; m_rr = !m_rr;
    end else begin
      order[0] = u1 ? 1 : 0; order[1] = 0; n = 1;
    end
    nxt = s; exp_lows = 0;
    for (int i = 0; i < n; i++) begin
      c = order[i];
      predict(nxt, c == 1 ? v1 : v0, a[c], kb[c], nd[c], er[c], lw[c]);
      m_div = nd[c];
      if (kb[c] >= 0) begin
        m_rise = kb[c] + RST;
        exp_chg.push_back(kb[c]);
      end
      exp_lows += lw[c];
      nxt = a[c] + 1;
    end
    bus.div0 = 16'(v0); bus.div1 = 16'(v1);
    bus.req0 = u0;      bus.req1 = u1;
    prev_div = int'(bus.divisor);
    lows_seen = 0; stray_err = 0; done = 1'b0;
    ack_cnt[0] = 0; ack_cnt[1] = 0; got_ack[0] = -1; got_ack[1] = -1;
    got_div[0] = -1; got_div[1] = -1; got_err[0] = 1'b0; got_err[1] = 1'b0;
    for (int t = 0; t < 300 && !done; t++) begin
      step();
      if (t == 0) chk("busy_after_grant", bus.busy, 1);
      if (!bus.div_rst_n) lows_seen++;
      if (int'(bus.divisor) != prev_div) begin
        got_chg.push_back(cyc);
        prev_div = int'(bus.divisor);
      end
      if (bus.err && !bus.ack0 && !bus.ack1) stray_err++;
      if (bus.ack0) begin
        ack_cnt[0]++; got_ack[0] = cyc; got_err[0] = bus.err; got_div[0] = int'(bus.divisor);
        bus.req0 = 1'b0;
      end
      if (bus.ack1) begin
        ack_cnt[1]++; got_ack[1] = cyc; got_err[1] = bus.err; got_div[1] = int'(bus.divisor);
        bus.req1 = 1'b0;
      end
      done = (ack_cnt[0] >= int'(u0)) && (ack_cnt[1] >= int'(u1));
    end
    bus.req0 = 1'b0; bus.req1 = 1'b0;
    chk("round_completes", done, 1);
    chk("ack0_count", ack_cnt[0], int'(u0));
    chk("ack1_count", ack_cnt[1], int'(u1));
    for (int i = 0; i < n; i++) begin
      c = order[i];
      chk(c == 1 ? "ack1_edge" : "ack0_edge", got_ack[c], a[c]);
      chk(c == 1 ? "err1" : "err0", got_err[c], er[c]);
      chk(c == 1 ? "div_at_ack1" : "div_at_ack0", got_div[c], nd[c]);
    end
    chk("rst_low_cycles", lows_seen, exp_lows);
    chk("stray_err", stray_err, 0);
    chk("change_count", got_chg.size(), exp_chg.size());
    for (int i = 0; i < exp_chg.size() && i < got_chg.size(); i++)
      chk("change_edge", got_chg[i], exp_chg[i]);
    chk("busy_at_last_ack", bus.busy, 0);
  endtask

  function automatic int rand_div();
    int r;
    r = int'($urandom_range(0, 9));
    if (r == 0) return 0;
    if (r == 1) return m_div;
    return int'($urandom_range(1, 14));
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int ack_seen;
    int mode;
    bus.req0 = 1'b0; bus.req1 = 1'b0; bus.div0 = '0; bus.div1 = '0;
    rst_n = 1'b0;
    repeat (5) step();
    chk("rst_divisor", bus.divisor, RDIV);
    chk("rst_div_rst_n", bus.div_rst_n, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_ack0", bus.ack0, 0);
    chk("rst_ack1", bus.ack1, 0);
    chk("rst_err", bus.err, 0);

    rst_n = 1'b1;
    m_div = RDIV; m_rise = cyc + 1; m_rr = 1'b0;
    step();
    chk("release_div_rst_n", bus.div_rst_n, 1);
    chk("release_busy", bus.busy, 0);

    round(1'b1, 1'b0, 3, 0);
    round(1'b1, 1'b1, 8, 2);
    round(1'b0, 1'b1, 0, 0);
    chk("div_after_reject", bus.divisor, 2);

    // Reset while a change to 9 is waiting for its boundary.
    bus.div0 = 16'd9; bus.req0 = 1'b1;
    step();
    step();
    chk("midrst_busy_before", bus.busy, 1);
    rst_n = 1'b0;
    #1;
    chk("midrst_divisor", bus.divisor, RDIV);
    chk("midrst_div_rst_n", bus.div_rst_n, 0);
    chk("midrst_busy", bus.busy, 0);
    chk("midrst_ack0", bus.ack0, 0);
    bus.req0 = 1'b0;
    ack_seen = 0;
    repeat (3) begin
      step();
      if (bus.ack0 || bus.ack1) ack_seen++;
    end
    rst_n = 1'b1;
    m_div = RDIV; m_rise = cyc + 1; m_rr = 1'b0;
    repeat (4) begin
      step();
      if (bus.ack0 || bus.ack1) ack_seen++;
    end
    chk("midrst_no_ack", ack_seen, 0);
    chk("midrst_divisor_after", bus.divisor, RDIV);
    chk("midrst_release", bus.div_rst_n, 1);

    round(1'b1, 1'b0, RDIV, 0);
    round(1'b1, 1'b1, 4, 7);
    round(1'b1, 1'b1, 6, 3);

    for (int i = 0; i < 30; i++) begin
      mode = int'($urandom_range(0, 2));
      if (mode == 0)      round(1'b1, 1'b0, rand_div(), 0);
      else if (mode == 1) round(1'b0, 1'b1, 0, rand_div());
      else                round(1'b1, 1'b1, rand_div(), rand_div());
      repeat (int'($urandom_range(0, 3))) step();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
